byte_serial_add_seq: RTL and testbench
======================================

// Module: byte_serial_add_seq
// PURPOSE
//  Sequences a single 8-bit ripple-carry adder slice over NBYTES cycles to add two
//  8*NBYTES-bit operands, least-significant byte first, with carry held in a register.
//  Trades latency for area in front of the 8-bit adder datapath.
//  Start/busy/done handshake towards the requesting logic.
// PARAMETERS
//  NBYTES  4  operand width in bytes (legal 2..8); operand width W = 8*NBYTES
// PORTS
//  clk    in   1  single clock, rising edge
//  rst    in   1  asynchronous, active-high reset
//  start  in   1  request; sampled only in IDLE
//  a_in   in   W  operand A, sampled on accepted start
//  b_in   in   W  operand B, sampled on accepted start
//  busy   out  1  high in RUN and DONE
//  done   out  1  one-cycle pulse, result valid
//  sum    out  W  result; holds until next accepted start
//  cout   out  1  final carry out of MS byte; holds with sum
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, idx=0, carry=0, A/B regs=0, sum=0, cout=0,
//    busy=0, done=0. Reset mid-RUN abandons the operation; no done pulse follows.
//  - States: IDLE, RUN, DONE (2-bit encoding, unused code -> IDLE).
//  - IDLE: busy=0. start=1 -> latch a_in/b_in, carry<=0, idx<=0, sum<=0, cout<=0, go RUN.
//  - RUN: each cycle slice computes {c,s} = A[idx]+B[idx]+carry (9-bit, ripple);
//    sum[8*idx+:8]<=s, carry<=c, idx<=idx+1. When idx==NBYTES-1: cout<=c, go DONE.
//  - DONE: done=1 for exactly one cycle, busy=1; next state IDLE unconditionally.
//  - Latency: start accepted at edge 0 -> done high in cycle NBYTES+1 (5 for NBYTES=4);
//    next start accepted the cycle after done -> throughput one op per NBYTES+2 cycles.
//  - start while busy (RUN or DONE) ignored; no queueing; operand changes during RUN
//    do not affect result (registered copies used).
//  - Arithmetic: unsigned modulo 2^W; cout is bit W of the true sum.
//  - idx width = clog2(NBYTES), never wraps past NBYTES-1.
//  - sum bytes above idx are 0 while RUN; sum/cout only meaningful from the done cycle.
// CONFIGURATION
//  ADDSEQ_SUB_EN defined: extra port  sub in 1, sampled with start. sub=1 -> B bytes
//    inverted in the slice and initial carry=1 (A-B two's complement); cout=1 means
//    no borrow (A>=B). sub=0 identical to add-only build.
//  ADDSEQ_SUB_EN undefined: no sub port; add only; initial carry always 0.
// TESTING (NBYTES=4 unless noted)
//  1. rst pulse with clk idle -> all outputs 0 without a clock edge.
//  2. start, A=0x000000FF, B=0x00000001 -> done at cycle 5, sum=0x00000100, cout=0.
//  3. start, A=0xFFFFFFFF, B=0x00000001 -> sum=0x00000000, cout=1 (carry through all bytes).
//  4. start A=0x12345678,B=0x11111111; at cycle 2 start again with A=B=0xFFFFFFFF ->
//     only one done, sum=0x23456789, cout=0; following start accepted after done.
//  5. start, assert rst in cycle 2 of RUN -> sum=0,busy=0,no done; then
//     A=0x80000000,B=0x80000000 -> sum=0, cout=1.
//  6. ADDSEQ_SUB_EN: sub=1, A=0x00000005, B=0x00000007 -> sum=0xFFFFFFFE, cout=0;
//     sub=1, A=7, B=5 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/byte_serial_add_seq_if.sv
// Start/busy/done handshake and operand/result bus for byte_serial_add_seq.
// ADDSEQ_SUB_EN adds the 'sub' request bit.
interface byte_serial_add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
`ifdef ADDSEQ_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, a_in, b_in,
`ifdef ADDSEQ_SUB_EN
        output sub,
`endif
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a_in, b_in,
`ifdef ADDSEQ_SUB_EN
        input  sub,
`endif
        output busy, done, sum, cout
    );
endinterface

// File: rtl/byte_serial_add_seq.sv
// Byte-serial adder: one 8-bit ripple slice walks the operands LS byte first.
// ADDSEQ_SUB_EN enables A-B via inverted B bytes and an initial carry of 1.
module byte_serial_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_serial_add_seq_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sub_q, sub_d;

    logic [IW+2:0] bit_lo;
    logic [7:0]    a_byte, b_byte;
    logic [8:0]    slice;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        sub_d   = sub_q;

        bit_lo = {idx_q, 3'b000};
        a_byte = a_q[bit_lo +: 8];
        // Subtraction feeds the slice ~B; the +1 comes from the seeded carry.
        b_byte = b_q[bit_lo +: 8] ^ {8{sub_q}};
        slice  = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
`ifdef ADDSEQ_SUB_EN
                    sub_d   = bus.sub;
                    carry_d = bus.sub;
`else
                    sub_d   = 1'b0;
                    carry_d = 1'b0;
`endif
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[bit_lo +: 8] = slice[7:0];
                carry_d            = slice[8];
                if (idx_q == LAST) begin
                    cout_d  = slice[8];
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Handshake outputs are registered off the next state.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sub_q   <= sub_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Scoreboard bench for byte_serial_add_seq (NBYTES=4); sub tests under ADDSEQ_SUB_EN.
module tb_byte_serial_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   clk_en = 1'b0;

    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    byte_serial_add_seq_if #(.NBYTES(NB)) bus ();

    byte_serial_add_seq #(.NBYTES(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock held idle until the async reset check is done.
    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drive a request, push the reference result, hold start until accepted.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic sub, output int edges);
        logic [W:0] full;
        full = sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
        sb.push_back('{sum: full[W-1:0], cout: full[W]});
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
`ifdef ADDSEQ_SUB_EN
        bus.sub   = sub;
`endif
        edges = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) begin
                edges = k;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    // Cycle index (accept edge = cycle 1) at which done is seen; 0 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 2; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b0;
        bus.a_in  = '0;
        bus.b_in  = '0;
`ifdef ADDSEQ_SUB_EN
        bus.sub   = 1'b0;
`endif
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %h expected 0", bus.sum); end
        checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int   edges, lat;
        exp_t e;
        drive_start(a, b, 1'b0, edges);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b expected 1", name, bus.busy); end
        wait_done(lat);
        checks++; if (lat !== NB + 1) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, NB + 1); end
        e = sb.pop_front();
        checks++; if (bus.sum !== e.sum) begin errors++; $display("FAIL %s_sum: got %h expected %h", name, bus.sum, e.sum); end
        checks++; if (bus.cout !== e.cout) begin errors++; $display("FAIL %s_cout: got %b expected %b", name, bus.cout, e.cout); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: got done=%b busy=%b expected 0 0", name, bus.done, bus.busy);
        end
        checks++; if (bus.sum !== e.sum) begin errors++; $display("FAIL %s_sum_hold: got %h expected %h", name, bus.sum, e.sum); end
    endtask

    task automatic test_ignore_start;
        int   edges, lat, d0;
        exp_t e;
        d0 = done_cnt;
        drive_start(32'h12345678, 32'h11111111, 1'b0, edges);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.a_in  = 32'hFFFFFFFF;
        bus.b_in  = 32'hFFFFFFFF;
        repeat (2) begin @(posedge clk); #1; end
        bus.start = 1'b0;
        lat = 0;
        for (int n = 0; n < 10; n++) begin
            if (bus.done === 1'b1) begin lat = 1; break; end
            @(posedge clk); #1;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ignore_done_seen: got %0d expected 1", lat); end
        e = sb.pop_front();
        checks++; if (bus.sum !== e.sum) begin errors++; $display("FAIL ignore_sum: got %h expected %h", bus.sum, e.sum); end
        checks++; if (bus.cout !== e.cout) begin errors++; $display("FAIL ignore_cout: got %b expected %b", bus.cout, e.cout); end
        // Next request raised in the done cycle: accepted on the second edge.
        drive_start(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, edges);
        checks++; if (edges !== 2) begin errors++; $display("FAIL ignore_accept_edges: got %0d expected 2", edges); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", done_cnt - d0); end
        wait_done(lat);
        checks++; if (lat !== NB + 1) begin errors++; $display("FAIL ignore_next_latency: got %0d expected %0d", lat, NB + 1); end
        e = sb.pop_front();
        checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin
            errors++; $display("FAIL ignore_next_result: got %h/%b expected %h/%b", bus.sum, bus.cout, e.sum, e.cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run;
        int d0;
        bus.start = 1'b1;
        bus.a_in  = 32'h11223344;
        bus.b_in  = 32'h01010101;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        d0  = done_cnt;
        rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.sum !== '0) begin
            errors++; $display("FAIL midrst_async: got busy=%b sum=%h expected 0 0", bus.busy, bus.sum);
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midrst_no_done: got %0d extra expected 0", done_cnt - d0); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] av[6] = '{32'h00000000, 32'hFFFFFFFF, 32'h00FF00FF, 32'h0, 32'h0, 32'h0};
        logic [W-1:0] bv[6] = '{32'h00000000, 32'hFFFFFFFF, 32'hFF01FF01, 32'h0, 32'h0, 32'h0};
        int   edges, lat;
        exp_t e;
        for (int i = 3; i < 6; i++) begin
            av[i] = $urandom;
            bv[i] = $urandom;
        end
        for (int i = 0; i < 6; i++) begin
            drive_start(av[i], bv[i], 1'b0, edges);
            if (i > 0) begin
                checks++; if (edges !== 2) begin errors++; $display("FAIL b2b_accept_%0d: got %0d expected 2", i, edges); end
            end
            wait_done(lat);
            checks++; if (lat !== NB + 1) begin errors++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, lat, NB + 1); end
            e = sb.pop_front();
            checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin
                errors++; $display("FAIL b2b_result_%0d: got %h/%b expected %h/%b", i, bus.sum, bus.cout, e.sum, e.cout);
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub;
        logic [W-1:0] av[3] = '{32'h00000005, 32'h00000007, 32'h80000000};
        logic [W-1:0] bv[3] = '{32'h00000007, 32'h00000005, 32'h80000000};
        int   edges, lat;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            drive_start(av[i], bv[i], 1'b1, edges);
            wait_done(lat);
            e = sb.pop_front();
            checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin
                errors++; $display("FAIL sub_result_%0d: got %h/%b expected %h/%b", i, bus.sum, bus.cout, e.sum, e.cout);
            end
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset;
        test_add("carry_byte", 32'h000000FF, 32'h00000001);
        test_add("carry_all", 32'hFFFFFFFF, 32'h00000001);
        test_ignore_start;
        test_reset_mid_run;
        test_add("msb_carry", 32'h80000000, 32'h80000000);
        test_back_to_back;
`ifdef ADDSEQ_SUB_EN
        test_sub;
`endif
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
